// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
//   state_t       : FSM state encoding (IDLE, RUN, DONE)
//   cnt_width()   : step-counter width for a given number of RUN steps
package serial_adder_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Counter width able to hold 0..steps-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned steps);
    int unsigned w;
    w = (steps <= 1) ? 1 : $clog2(steps);
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational ripple of DIGIT full-adder cells.
//   a, b  : DIGIT-bit operand slices
//   cin   : carry into bit 0
//   sum   : DIGIT-bit sum slice
//   cout  : carry out of the top bit
//   ctop  : carry into the top bit (used for signed overflow)
module adder_digit #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             ctop
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit, carry rippling upward
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[DIGIT];
  assign ctop = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a registered
// carry, start/busy/done handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted only in IDLE or DONE
//   A, B       : operands, captured on an accepted start
//   Cin        : carry-in (ignored when sub=1)
//   sub        : 0 = A+B+Cin, 1 = A-B
//   busy       : high while operating
//   done       : one-cycle pulse when Sum/Cout/Ovf are valid
//   Sum        : result, held until the next result completes
//   Cout       : carry-out (sub mode: 1 = no borrow)
//   Ovf        : two's-complement overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CW    = cnt_width(STEPS);

  // Reject illegal parameter combinations at elaboration
  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder: DIGIT must be >=1 and divide WIDTH exactly");
  end

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             dctop;
  logic             last_c;
  logic             accept_c;

  // Datapath: one digit per cycle from the low end of the operand registers
  adder_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .cin  (carry),
    .sum  (dsum),
    .cout (dcout),
    .ctop (dctop)
  );

  assign last_c   = (cnt == CW'(STEPS - 1));
  assign accept_c = start && ((state_q == IDLE) || (state_q == DONE));

  // New sum digit enters at the top so the LSB digit lands at bit 0 after STEPS shifts
  assign res_nxt = (res_sh >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, serial processing and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      Sum    <= '0;
      Cout   <= 1'b0;
      Ovf    <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      busy <= (state_d == RUN);
      done <= (state_d == DONE);

      if (accept_c) begin
        // Subtraction is A + ~B + 1, so invert B and force carry-in
        a_sh   <= A;
        b_sh   <= sub ? ~B : B;
        carry  <= sub ? 1'b1 : Cin;
        res_sh <= '0;
        cnt    <= '0;
      end else if (state_q == RUN) begin
        a_sh   <= a_sh >> DIGIT;
        b_sh   <= b_sh >> DIGIT;
        res_sh <= res_nxt;
        carry  <= dcout;
        cnt    <= cnt + CW'(1);
        if (last_c) begin
          // Final digit holds the MSB, so its top-bit carry-in is the carry into bit WIDTH-1
          Sum  <= res_nxt;
          Cout <= dcout;
          Ovf  <= dctop ^ dcout;
        end
      end
    end
  end

endmodule
